// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop rx synchroniser, majority-vote bit
// decisions, optional parity, 1/2 stop bits, valid/ack output register
// with parity/framing/overrun flags.
module uart_rx_os #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 5,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 tick,
  input  logic                 rx,
  input  logic                 rd_ack,
  input  logic                 clr,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW   = $clog2(OVERSAMPLE + 1);
  localparam int HALF = OVERSAMPLE / 2;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_e;

  state_e               state_q, state_d;
  logic                 meta_q, sync_q;
  logic [CW-1:0]        smp_q, smp_d;
  logic [CW-1:0]        ones_q, ones_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 dv_q, dv_d, pe_q, pe_d, fe_q, fe_d, ovr_q, ovr_d;

  logic [CW-1:0] ones_nxt;
  logic          last_smp, voted, exp_par, ferr_nxt, done;

  assign ones_nxt = ones_q + CW'(sync_q);
  assign last_smp = (smp_q == CW'(OVERSAMPLE - 1));
  assign voted    = (ones_nxt > CW'(HALF));
  // Expected parity bit: XOR of data for even, inverted for odd.
  assign exp_par  = (^shreg_q) ^ (PARITY_MODE == 2);
  assign ferr_nxt = ferr_q | ~voted;

  // Synchronise the asynchronous rx pin; idle level is high.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
    end
  end

  // Receive FSM: advances only on tick, votes each bit over OVERSAMPLE samples.
  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    ones_d  = ones_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done    = 1'b0;
    if (tick) begin
      if (state_q != S_IDLE && state_q != S_WAIT_HIGH) begin
        if (last_smp) begin
          smp_d  = '0;
          ones_d = '0;
        end else begin
          smp_d  = smp_q + CW'(1);
          ones_d = ones_nxt;
        end
      end
      case (state_q)
        S_IDLE: begin
          // The falling-edge tick is already sample 1 of the start bit.
          if (!sync_q) begin
            state_d = S_START;
            smp_d   = CW'(1);
            ones_d  = '0;
            bit_d   = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end
        S_START: begin
          if (last_smp) state_d = voted ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          if (last_smp) begin
            shreg_d = {voted, shreg_q[DATA_BITS-1:1]};
            if (bit_q == 4'(DATA_BITS - 1)) begin
              bit_d   = '0;
              state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (last_smp) begin
            perr_d  = (voted != exp_par);
            state_d = S_STOP;
          end
        end
        S_STOP: begin
          if (last_smp) begin
            ferr_d = ferr_nxt;
            if (bit_q == 4'(STOP_BITS - 1)) begin
              bit_d   = '0;
              done    = 1'b1;
              state_d = ferr_nxt ? S_WAIT_HIGH : S_IDLE;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end
        S_WAIT_HIGH: begin
          // A held-low break line must go high before a new start is accepted.
          if (sync_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output register: ack clears, completion loads or flags overrun, clr wins.
  always_comb begin
    dout_d = dout_q;
    dv_d   = dv_q;
    pe_d   = pe_q;
    fe_d   = fe_q;
    ovr_d  = ovr_q;
    if (dv_q && rd_ack) begin
      dv_d = 1'b0;
      pe_d = 1'b0;
      fe_d = 1'b0;
    end
    if (done) begin
      if (!dv_q || rd_ack) begin
        dout_d = shreg_q;
        dv_d   = 1'b1;
        pe_d   = perr_q;
        fe_d   = ferr_nxt;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (clr) begin
      dout_d = '0;
      dv_d   = 1'b0;
      pe_d   = 1'b0;
      fe_d   = 1'b0;
      ovr_d  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= S_IDLE;
      smp_q   <= '0;
      ones_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      ones_q  <= ones_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: four instances (8N1/OS5, 8E1/OS5, 8O1/OS5, 7N2/OS9),
// sample-level frame generator with minority noise, queue scoreboard.
module tb_uart_rx_os;

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       tick = 1'b0;
  logic [2:0] rx_v = 3'b111;   // 0: 8N1, 1: parity pair, 2: 7N2
  logic [3:0] ack_v = '0;      // per instance: 0 A, 1 E, 2 O, 3 D
  logic [3:0] clr_v = '0;
  logic [7:0] dout_a, dout_e, dout_o;
  logic [6:0] dout_d;
  logic [3:0] dv, pe, fe, ov;

  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(5), .PARITY_MODE(0), .STOP_BITS(1)) u_a (
    .clk(clk), .res(res), .tick(tick), .rx(rx_v[0]), .rd_ack(ack_v[0]), .clr(clr_v[0]),
    .data_out(dout_a), .data_valid(dv[0]), .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]));
  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(5), .PARITY_MODE(1), .STOP_BITS(1)) u_e (
    .clk(clk), .res(res), .tick(tick), .rx(rx_v[1]), .rd_ack(ack_v[1]), .clr(clr_v[1]),
    .data_out(dout_e), .data_valid(dv[1]), .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]));
  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(5), .PARITY_MODE(2), .STOP_BITS(1)) u_o (
    .clk(clk), .res(res), .tick(tick), .rx(rx_v[1]), .rd_ack(ack_v[2]), .clr(clr_v[2]),
    .data_out(dout_o), .data_valid(dv[2]), .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]));
  uart_rx_os #(.DATA_BITS(7), .OVERSAMPLE(9), .PARITY_MODE(0), .STOP_BITS(2)) u_d (
    .clk(clk), .res(res), .tick(tick), .rx(rx_v[2]), .rd_ack(ack_v[3]), .clr(clr_v[3]),
    .data_out(dout_d), .data_valid(dv[3]), .parity_err(pe[3]), .frame_err(fe[3]), .overrun(ov[3]));

  int os_c[3] = '{5, 5, 9};
  int nb_c[3] = '{8, 8, 7};
  int hp_c[3] = '{0, 1, 0};
  int sb_c[3] = '{1, 1, 2};

  exp_t q0[$], q1[$], q2[$], q3[$];
  logic smp[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial forever #5 clk = ~clk;

  // One-cycle tick every 4 clocks.
  initial forever begin
    repeat (3) @(posedge clk);
    #1 tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: frame content straight from the line rules.
  function automatic exp_t model(input logic [8:0] d, input int nb, input int pm,
                                 input logic pb, input logic [1:0] stops, input int sb);
    exp_t r;
    int   ones = 0;
    for (int i = 0; i < nb; i++) ones += int'(d[i]);
    r.d  = d & 9'((1 << nb) - 1);
    r.pe = (pm != 0) && (pb != (((ones % 2) == 1) ^ (pm == 2)));
    r.fe = (stops[0] == 1'b0) || (sb == 2 && stops[1] == 1'b0);
    return r;
  endfunction

  task automatic push_exp(input int id, input logic [8:0] d, input logic pb, input logic [1:0] stops);
    case (id)
      0: q0.push_back(model(d, 8, 0, pb, stops, 1));
      1: begin
        q1.push_back(model(d, 8, 1, pb, stops, 1));
        q2.push_back(model(d, 8, 2, pb, stops, 1));
      end
      default: q3.push_back(model(d, 7, 0, pb, stops, 2));
    endcase
  endtask

  task automatic set_ctl(input int id, input bit is_clr, input bit v);
    logic [3:0] m;
    m = (id == 0) ? 4'b0001 : (id == 1) ? 4'b0110 : 4'b1000;
    if (is_clr) clr_v = v ? (clr_v | m) : (clr_v & ~m);
    else        ack_v = v ? (ack_v | m) : (ack_v & ~m);
  endtask

  // Leaves us 2 ns after a tick edge so the next rx value clears the synchroniser.
  task automatic align();
    do @(negedge clk); while (tick !== 1'b1);
    @(posedge clk);
    #2;
  endtask

  // Present one sample for one tick; ev 1/2 pulses ack/clr on that tick's edge.
  task automatic send_sample(input int id, input logic v, input int ev);
    rx_v[id] = v;
    do @(negedge clk); while (tick !== 1'b1);
    if (ev != 0) set_ctl(id, ev == 2, 1'b1);
    @(posedge clk);
    #2;
    if (ev != 0) set_ctl(id, ev == 2, 1'b0);
  endtask

  task automatic pulse(input int id, input bit is_clr);
    @(negedge clk);
    set_ctl(id, is_clr, 1'b1);
    @(posedge clk);
    #2;
    set_ctl(id, is_clr, 1'b0);
    align();
  endtask

  // Sample stream for a frame; noise<0 picks a random minority per bit.
  task automatic build(input int id, input logic [8:0] d, input logic pb,
                       input logic [1:0] stops, input int noise);
    logic bits[$];
    logic fl[16];
    int   os, nf, cnt, p;
    os = os_c[id];
    bits.push_back(1'b0);
    for (int i = 0; i < nb_c[id]; i++) bits.push_back(d[i]);
    if (hp_c[id] != 0) bits.push_back(pb);
    for (int i = 0; i < sb_c[id]; i++) bits.push_back(stops[i]);
    smp.delete();
    for (int b = 0; b < bits.size(); b++) begin
      nf = (noise < 0) ? int'($urandom_range(0, os / 2)) : noise;
      for (int k = 0; k < 16; k++) fl[k] = 1'b0;
      cnt = 0;
      while (cnt < nf) begin
        // First start sample stays low so the frame begins on that tick.
        p = int'($urandom_range((b == 0) ? 1 : 0, os - 1));
        if (!fl[p]) begin
          fl[p] = 1'b1;
          cnt++;
        end
      end
      for (int k = 0; k < os; k++) smp.push_back(bits[b] ^ fl[k]);
    end
  endtask

  task automatic frame(input int id, input logic [8:0] d, input logic pb, input logic [1:0] stops,
                       input int noise, input bit push, input int ev_last);
    build(id, d, pb, stops, noise);
    if (push) push_exp(id, d, pb, stops);
    for (int i = 0; i < smp.size(); i++)
      send_sample(id, smp[i], (i == smp.size() - 1) ? ev_last : 0);
    send_sample(id, 1'b1, 0);
    send_sample(id, 1'b1, 0);
  endtask

  task automatic pop_cmp(input int i);
    exp_t       e;
    logic       have;
    logic [8:0] d;
    have = 1'b0;
    e = '0;
    case (i)
      0: begin d = {1'b0, dout_a}; have = q0.size() > 0; if (have) e = q0.pop_front(); end
      1: begin d = {1'b0, dout_e}; have = q1.size() > 0; if (have) e = q1.pop_front(); end
      2: begin d = {1'b0, dout_o}; have = q2.size() > 0; if (have) e = q2.pop_front(); end
      default: begin d = {2'b0, dout_d}; have = q3.size() > 0; if (have) e = q3.pop_front(); end
    endcase
    if (!have) begin
      n_cmp++;
      n_bad++;
      $display("FAIL dut%0d unexpected word: got %0h want none", i, d);
    end else begin
      chk($sformatf("dut%0d data", i), 32'(d), 32'(e.d));
      chk($sformatf("dut%0d parity_err", i), 32'(pe[i]), 32'(e.pe));
      chk($sformatf("dut%0d frame_err", i), 32'(fe[i]), 32'(e.fe));
    end
  endtask

  // Monitor: a word is presented when valid rises or stays up across an ack.
  initial begin
    logic [3:0] pv;
    pv = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++)
        if (dv[i] && (!pv[i] || ack_v[i])) pop_cmp(i);
      pv = dv;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("reset data_valid", 32'(dv), 0);
    chk("reset overrun", 32'(ov), 0);
    chk("reset data_out", 32'({dout_a, dout_d}), 0);
    res = 1'b1;
    align();

    // Clean 0xA5: valid must rise exactly on the 50th tick.
    build(0, 9'h0A5, 1'b0, 2'b11, 0);
    push_exp(0, 9'h0A5, 1'b0, 2'b11);
    for (int i = 0; i < smp.size() - 1; i++) send_sample(0, smp[i], 0);
    chk("valid before tick 50", 32'(dv[0]), 0);
    send_sample(0, smp[smp.size() - 1], 0);
    chk("valid at tick 50", 32'(dv[0]), 1);
    chk("a5 overrun", 32'(ov[0]), 0);
    pulse(0, 1'b0);
    chk("ack clears valid", 32'(dv[0]), 0);
    chk("ack keeps data", 32'(dout_a), 32'h0A5);

    // Two-of-five noise, then a glitch start, then a clean frame.
    frame(0, 9'h03C, 1'b0, 2'b11, 2, 1'b1, 0);
    pulse(0, 1'b0);
    send_sample(0, 1'b0, 0);
    send_sample(0, 1'b0, 0);
    for (int i = 0; i < 6; i++) send_sample(0, 1'b1, 0);
    chk("false start no valid", 32'(dv[0]), 0);
    frame(0, 9'h081, 1'b0, 2'b11, 0, 1'b1, 0);
    pulse(0, 1'b0);

    // Parity pair: same line, even and odd instances.
    frame(1, 9'h007, 1'b0, 2'b11, 0, 1'b1, 0);
    chk("even pb0 perr", 32'(pe[1]), 1);
    chk("odd pb0 perr", 32'(pe[2]), 0);
    pulse(1, 1'b0);
    frame(1, 9'h007, 1'b1, 2'b11, 0, 1'b1, 0);
    chk("even pb1 perr", 32'(pe[1]), 0);
    chk("odd pb1 perr", 32'(pe[2]), 1);
    pulse(1, 1'b0);

    // Framing error, then a 200-tick break yields exactly one 0x00 frame.
    frame(0, 9'h055, 1'b0, 2'b10, 0, 1'b1, 0);
    chk("stop low frame_err", 32'(fe[0]), 1);
    chk("stop low valid", 32'(dv[0]), 1);
    pulse(0, 1'b0);
    push_exp(0, 9'h000, 1'b0, 2'b00);
    for (int i = 0; i < 200; i++) send_sample(0, 1'b0, 0);
    chk("break frame_err", 32'(fe[0]), 1);
    chk("break no overrun", 32'(ov[0]), 0);
    send_sample(0, 1'b1, 0);
    send_sample(0, 1'b1, 0);
    pulse(0, 1'b0);
    frame(0, 9'h012, 1'b0, 2'b11, 0, 1'b1, 0);
    chk("after break frame_err", 32'(fe[0]), 0);
    pulse(0, 1'b0);

    // Overrun, clr, coincident ack, clr beating completion.
    frame(0, 9'h011, 1'b0, 2'b11, 0, 1'b1, 0);
    frame(0, 9'h022, 1'b0, 2'b11, 0, 1'b0, 0);
    chk("overrun keeps old", 32'(dout_a), 32'h011);
    chk("overrun set", 32'(ov[0]), 1);
    pulse(0, 1'b1);
    chk("clr all", 32'({dout_a, dv[0], pe[0], fe[0], ov[0]}), 0);
    frame(0, 9'h044, 1'b0, 2'b11, 0, 1'b1, 0);
    frame(0, 9'h033, 1'b0, 2'b11, 0, 1'b1, 1);
    chk("coinc ack data", 32'(dout_a), 32'h033);
    chk("coinc ack valid", 32'(dv[0]), 1);
    chk("coinc ack no overrun", 32'(ov[0]), 0);
    pulse(0, 1'b1);
    frame(0, 9'h077, 1'b0, 2'b11, 0, 1'b0, 2);
    chk("clr beats completion valid", 32'(dv[0]), 0);
    chk("clr beats completion overrun", 32'(ov[0]), 0);

    // Reset mid-data on both the 8N1 and 7N2 instances.
    for (int id = 0; id < 3; id += 2) begin
      frame(id, 9'h06B, 1'b0, 2'b11, 0, 1'b1, 0);
      build(id, 9'h0F0, 1'b0, 2'b11, 0);
      for (int i = 0; i < 4 * os_c[id]; i++) send_sample(id, smp[i], 0);
      res = 1'b0;
      #1;
      chk($sformatf("id%0d async reset outputs", id),
          32'({dout_a, dout_d, dv, pe, fe, ov}), 0);
      rx_v[id] = 1'b1;
      repeat (2) @(posedge clk);
      #2 res = 1'b1;
      align();
      send_sample(id, 1'b1, 0);
      frame(id, (id == 0) ? 9'h09E : 9'h05A, 1'b0, 2'b11, 0, 1'b1, 0);
      chk($sformatf("id%0d after reset valid", id), 32'(dv[id == 0 ? 0 : 3]), 1);
      pulse(id, 1'b0);
    end

    // Randomised frames with minority noise on every instance.
    for (int id = 0; id < 3; id++) begin
      for (int n = 0; n < 15; n++) begin
        logic [8:0] d;
        logic       pb;
        logic [1:0] st;
        d  = 9'($urandom_range(0, 511));
        pb = 1'($urandom_range(0, 1));
        st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
        frame(id, d, pb, st, -1, 1'b1, 0);
        pulse(id, 1'b0);
      end
    end
    chk("no overrun after random", 32'(ov), 0);

    repeat (8) @(posedge clk);
    chk("q0 drained", 32'(q0.size()), 0);
    chk("q1 drained", 32'(q1.size()), 0);
    chk("q2 drained", 32'(q2.size()), 0);
    chk("q3 drained", 32'(q3.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised oversampling UART receiver. Generalises the fixed 8-bit, 5-sample receiver: configurable data width, oversampling factor, parity and stop bits. Adds a valid/ack output handshake plus parity, framing and overrun flags. Sits between the board RX pin (after a baud-tick generator) and the command/loopback logic that consumes received bytes.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first
OVERSAMPLE, 5, samples per bit (ticks per bit), odd, legal 3..15
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2

Ports:
clk  in  1  system clock
res  in  1  asynchronous active-low reset
tick  in  1  sample enable, one-cycle pulse at OVERSAMPLE x baud
rx  in  1  serial input, asynchronous to clk
rd_ack  in  1  consumer accepts data_out (meaningful only while data_valid=1)
clr  in  1  synchronous clear of the output register and all flags
data_out  out  DATA_BITS  last received word
data_valid  out  1  data_out holds an unacknowledged word
parity_err  out  1  parity mismatch in the word on data_out
frame_err  out  1  stop bit sampled low in the word on data_out
overrun  out  1  sticky: a completed frame was dropped because data_valid=1

Behaviour:
- Reset (res=0, async): all outputs 0. FSM = IDLE. Counters 0. Synchroniser flops = 1.
- rx passes a 2-flop synchroniser; all sampling uses the synchronised value (2 clk latency).
- The FSM and counters advance only on cycles with tick=1. Without tick everything holds except the handshake and clr logic.
- States: IDLE, START, DATA, PARITY (skipped if PARITY_MODE=0), STOP, WAIT_HIGH.
- IDLE: a tick with rx=0 enters START. That tick counts as sample 1 of the start bit.
- Per bit: collect OVERSAMPLE samples with a sample counter. Majority vote: bit = 1 iff the count of ones > OVERSAMPLE/2 (integer division). The decision is made on the tick of the last sample.
- START: majority 1 means a false start; return to IDLE with no flags and no output. Majority 0 enters DATA.
- DATA: DATA_BITS voted bits are shifted in LSB first, then the FSM enters PARITY or STOP.
- PARITY: the voted bit is compared with the XOR of the data bits. For even parity the expected bit is that XOR; for odd parity it is its inverse. A mismatch sets an internal perr.
- STOP: STOP_BITS voted bits. Any stop bit voting 0 sets an internal ferr. Evaluation continues through all stop bits.
- Frame completion occurs on the tick of the last stop sample. The outputs update on that same clk edge.
- If data_valid=0, or rd_ack=1 in the same cycle: load data_out, parity_err=perr, frame_err=ferr, data_valid=1.
- If data_valid=1 and rd_ack=0: the new frame is dropped and overrun is set. data_out and the flags keep the old word.
- After completion: if ferr=1 the FSM goes to WAIT_HIGH; otherwise it goes to IDLE.
- WAIT_HIGH: stay until a tick with rx=1, then go to IDLE. This prevents a held-low break line from producing repeated frames.
- Handshake: rd_ack=1 while data_valid=1 clears data_valid, parity_err and frame_err on the next edge. data_out keeps its value. rd_ack while data_valid=0 is ignored.
- clr=1: data_out, data_valid, parity_err, frame_err and overrun all go to 0 on the next edge. Reception in progress is not aborted.
- clr has priority over frame completion in the same cycle: the completing frame is discarded and overrun is not set.
- overrun is cleared only by clr or reset.
- Reset mid-frame returns the block to IDLE immediately. The partial frame is lost.
- Latency: data_valid rises on the clk edge of the last stop-sample tick. For 8N1 with OVERSAMPLE=5 that is the 50th tick counted from the start-edge tick.

Test Plan:
- 8N1, OS=5, send 0xA5 at exactly 5 ticks/bit -> data_valid=1 on the 50th tick, data_out=0xA5, parity_err=frame_err=overrun=0. rd_ack pulse -> data_valid=0 next cycle, data_out stays 0xA5.
- Noise: flip 2 of 5 samples in every bit of 0x3C -> data_out=0x3C. Separately, a start bit low for only 2 samples then high -> no data_valid, FSM back in IDLE, the next clean 0x81 is received correctly.
- PARITY_MODE=1: send 0x07 with parity bit 0 -> data_out=0x07, parity_err=1. Send 0x07 with parity bit 1 -> parity_err=0. PARITY_MODE=2 with the same frames -> results inverted.
- Stop bit low on 0x55 -> frame_err=1, data_valid=1. Then hold rx low for 200 ticks -> exactly one further frame (0x00, frame_err=1) and nothing more until rx returns high. The next 0x12 is received clean.
- Two frames 0x11 then 0x22 with no rd_ack -> data_out=0x11, overrun=1. rd_ack coincident with completion of 0x33 -> data_out=0x33, data_valid=1, no new overrun. clr -> all outputs 0.
- res pulsed low mid-data of 0xF0 -> all outputs 0 immediately. Following frame 0x9E -> data_out=0x9E. Repeat the test with DATA_BITS=7, OVERSAMPLE=9, STOP_BITS=2 using 0x5A -> data_out=0x5A.
